// File: rtl/namuru_pkg.sv
// Register-map word indices and bus FSM encoding shared by the namuru
// Wishbone register page.
package namuru_pkg;

  localparam logic [7:0] IDX_STATUS     = 8'hE0;
  localparam logic [7:0] IDX_NEW_DATA   = 8'hE1;
  localparam logic [7:0] IDX_TIC_COUNT  = 8'hE2;
  localparam logic [7:0] IDX_HW_ID      = 8'hEF;
  localparam logic [7:0] IDX_RESET      = 8'hF0;
  localparam logic [7:0] IDX_PROG_TIC   = 8'hF1;
  localparam logic [7:0] IDX_PROG_ACCUM = 8'hF2;
  localparam logic [7:0] CHAN_LIMIT     = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHRD = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } wb_state_t;

  // Word indices below CHAN_LIMIT belong to the correlator bank.
  function automatic logic is_chan_idx(input logic [7:0] idx);
    return idx < CHAN_LIMIT;
  endfunction

endpackage

// File: rtl/namuru_sticky_flags.sv
// Sticky event bits: each set pulse latches a bit until a clear strobe;
// a set arriving on the clearing edge wins so no event is lost.
module namuru_sticky_flags #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_set,
  input  logic         i_clr,
  output logic [W-1:0] o_flags
);

  logic [W-1:0] r_flags;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flags <= '0;
    end else begin
      r_flags <= (r_flags & {W{~i_clr}}) | i_set;
    end
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/namuru_wb_slave.sv
// Wishbone classic responder for the namuru baseband register page: local
// control/status registers plus a strobe/data window onto the correlator bank.
module namuru_wb_slave
  import namuru_pkg::*;
#(
  parameter int          NUM_CHAN       = 12,
  parameter logic [31:0] HW_ID          = 32'h0000_4E41,
  parameter logic [23:0] PROG_TIC_RST   = 24'd999_999,
  parameter logic [23:0] PROG_ACCUM_RST = 24'd49_999,
  parameter logic [31:0] TIC_COUNT_RST  = 32'd0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  input  logic                tic_i,
  input  logic                accum_int_i,
  input  logic [NUM_CHAN-1:0] new_data_i,
  output logic                chan_we_o,
  output logic [7:0]          chan_adr_o,
  output logic [31:0]         chan_dat_o,
  input  logic [31:0]         chan_dat_i,
  output logic [23:0]         prog_tic_o,
  output logic [23:0]         prog_accum_int_o,
  output logic                soft_rst_o
);

  wb_state_t           r_state;
  wb_state_t           w_state_next;
  logic [7:0]          r_idx;
  logic                r_we;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_chan_we;
  logic [7:0]          r_chan_adr;
  logic [31:0]         r_chan_dat;
  logic                r_soft_rst;
  logic [23:0]         r_prog_tic;
  logic [23:0]         r_prog_accum;
  logic [31:0]         r_tic_count;

  logic [7:0]          w_idx;
  logic                w_req;
  logic                w_is_chan;
  logic                w_start;
  logic                w_commit;
  logic                w_load_rd;
  logic                w_clr_status;
  logic                w_clr_new;
  logic [1:0]          w_status_set;
  logic [1:0]          w_status;
  logic [NUM_CHAN-1:0] w_new_data;
  logic [31:0]         w_rd_data;
  logic                w_unused;

  assign w_idx        = wb_adr_i[9:2];
  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_is_chan    = is_chan_idx(w_idx);
  assign w_start      = (r_state == ST_IDLE) && w_req;
  assign w_commit     = w_start && wb_we_i;
  assign w_load_rd    = (w_start && !wb_we_i && !w_is_chan) || (r_state == ST_CHRD);
  assign w_clr_status = (r_state == ST_ACK) && !r_we && (r_idx == IDX_STATUS);
  assign w_clr_new    = (r_state == ST_ACK) && !r_we && (r_idx == IDX_NEW_DATA);
  assign w_status_set = {accum_int_i, tic_i};
  assign w_unused     = ^{wb_sel_i, wb_adr_i[31:10], wb_adr_i[1:0]};

  namuru_sticky_flags #(.W(2)) u_status (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_set   (w_status_set),
    .i_clr   (w_clr_status),
    .o_flags (w_status)
  );

  namuru_sticky_flags #(.W(NUM_CHAN)) u_new_data (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_set   (new_data_i),
    .i_clr   (w_clr_new),
    .o_flags (w_new_data)
  );

  // HOLD always separates ACK from the next IDLE so a lingering stb is not re-served.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_state_next = (!wb_we_i && w_is_chan) ? ST_CHRD : ST_ACK;
      ST_CHRD: w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_HOLD;
      ST_HOLD: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sticky snapshots fold in same-edge set pulses so a read never hides an event.
  always_comb begin
    w_rd_data = 32'd0;
    if (r_state == ST_CHRD) begin
      w_rd_data = chan_dat_i;
    end else begin
      case (w_idx)
        IDX_STATUS:     w_rd_data = {30'd0, w_status | w_status_set};
        IDX_NEW_DATA:   w_rd_data = 32'(w_new_data | new_data_i);
        IDX_TIC_COUNT:  w_rd_data = r_tic_count;
        IDX_HW_ID:      w_rd_data = HW_ID;
        IDX_PROG_TIC:   w_rd_data = {8'd0, r_prog_tic};
        IDX_PROG_ACCUM: w_rd_data = {8'd0, r_prog_accum};
        default:        w_rd_data = 32'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 8'd0;
      r_we       <= 1'b0;
      r_ack      <= 1'b0;
      r_dat      <= 32'd0;
      r_chan_we  <= 1'b0;
      r_chan_adr <= 8'd0;
      r_chan_dat <= 32'd0;
      r_soft_rst <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ack      <= (w_state_next == ST_ACK);
      r_chan_we  <= w_commit && w_is_chan;
      r_soft_rst <= w_commit && (w_idx == IDX_RESET);
      if (w_start) begin
        r_idx <= w_idx;
        r_we  <= wb_we_i;
      end
      if (w_start && w_is_chan) r_chan_adr <= w_idx;
      if (w_commit && w_is_chan) r_chan_dat <= wb_dat_i;
      if (w_load_rd) r_dat <= w_rd_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_prog_tic   <= PROG_TIC_RST;
      r_prog_accum <= PROG_ACCUM_RST;
      r_tic_count  <= TIC_COUNT_RST;
    end else begin
      if (w_commit && (w_idx == IDX_PROG_TIC))   r_prog_tic   <= wb_dat_i[23:0];
      if (w_commit && (w_idx == IDX_PROG_ACCUM)) r_prog_accum <= wb_dat_i[23:0];
      if (tic_i) r_tic_count <= r_tic_count + 32'd1;
    end
  end

  assign wb_ack_o         = r_ack;
  assign wb_dat_o         = r_dat;
  assign chan_we_o        = r_chan_we;
  assign chan_adr_o       = r_chan_adr;
  assign chan_dat_o       = r_chan_dat;
  assign soft_rst_o       = r_soft_rst;
  assign prog_tic_o       = r_prog_tic;
  assign prog_accum_int_o = r_prog_accum;

endmodule

// File: tb/tb_namuru_wb_slave.sv
// Bench for namuru_wb_slave: directed table, corner sequences and randomized
// traffic checked against a register-map model of the page.
module tb_namuru_wb_slave;

  localparam int          NC  = 12;
  localparam logic [31:0] HW  = 32'h0000_4E41;
  localparam logic [23:0] PT  = 24'd999_999;
  localparam logic [23:0] PA  = 24'd49_999;
  localparam logic [31:0] TCR = 32'hFFFF_FF00;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic          wb_ack_o;
  logic          tic_i = 1'b0;
  logic          accum_int_i = 1'b0;
  logic [NC-1:0] new_data_i = '0;
  logic          chan_we_o;
  logic [7:0]    chan_adr_o;
  logic [31:0]   chan_dat_o;
  logic [31:0]   chan_dat_i;
  logic [23:0]   prog_tic_o;
  logic [23:0]   prog_accum_int_o;
  logic          soft_rst_o;

  namuru_wb_slave #(
    .NUM_CHAN(NC), .HW_ID(HW), .PROG_TIC_RST(PT), .PROG_ACCUM_RST(PA), .TIC_COUNT_RST(TCR)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_ack_o(wb_ack_o), .tic_i(tic_i), .accum_int_i(accum_int_i), .new_data_i(new_data_i),
    .chan_we_o(chan_we_o), .chan_adr_o(chan_adr_o), .chan_dat_o(chan_dat_o),
    .chan_dat_i(chan_dat_i), .prog_tic_o(prog_tic_o), .prog_accum_int_o(prog_accum_int_o),
    .soft_rst_o(soft_rst_o)
  );

  always #5 sys_clk = ~sys_clk;

  // Correlator-bank stand-in: stores channel writes, returns data combinationally.
  logic [31:0] chan_mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_adr = '0;
  logic [31:0] poke_dat = '0;
  always @(posedge sys_clk) begin
    if (chan_we_o) chan_mem[chan_adr_o] <= chan_dat_o;
    if (poke_en) chan_mem[poke_adr] <= poke_dat;
  end
  assign chan_dat_i = chan_mem[chan_adr_o];

  int total = 0;
  int bad = 0;

  // Register-map model
  logic [1:0]    m_status;
  logic [NC-1:0] m_new;
  logic [31:0]   m_tic;
  logic [23:0]   m_pt;
  logic [23:0]   m_pa;
  logic [31:0]   m_chan [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_status = '0;
    m_new    = '0;
    m_tic    = TCR;
    m_pt     = PT;
    m_pa     = PA;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] idx);
    if (idx < 8'hE0) return m_chan[idx];
    case (idx)
      8'hE0:   return {30'd0, m_status};
      8'hE1:   return {20'd0, m_new};
      8'hE2:   return m_tic;
      8'hEF:   return HW;
      8'hF1:   return {8'd0, m_pt};
      8'hF2:   return {8'd0, m_pa};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_after_read(input logic [7:0] idx, input logic [NC-1:0] late_nd);
    if (idx == 8'hE0) m_status = '0;
    if (idx == 8'hE1) m_new = '0;
    m_new = m_new | late_nd;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic pulse(input logic t, input logic a, input logic [NC-1:0] nd);
    tic_i = t; accum_int_i = a; new_data_i = nd;
    tick();
    tic_i = 1'b0; accum_int_i = 1'b0; new_data_i = '0;
    m_status = m_status | {a, t};
    m_new    = m_new | nd;
    if (t) m_tic = m_tic + 32'd1;
  endtask

  // edges = clock edge (counted from the first one sampling stb) on which ack is seen; 0 = timeout.
  task automatic wb_read(input logic [31:0] adr, input logic [NC-1:0] clr_nd, input bit hold,
                         output logic [31:0] dat, output int edges);
    int n;
    wb_adr_i = adr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_ack_o && n < 8);
    edges = wb_ack_o ? n + 1 : 0;
    dat = wb_dat_o;
    if (!hold) bus_idle();
    new_data_i = clr_nd;
    tick();
    new_data_i = '0;
    check("rd_ack_width", {31'd0, wb_ack_o}, 32'd0);
    if (hold) begin
      tick();
      check("rd_ack_stb_held", {31'd0, wb_ack_o}, 32'd0);
    end
    bus_idle();
    tick();
    $display("rd adr=%h dat=%h edges=%0d", adr, dat, edges);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, output int edges);
    logic [7:0] idx;
    int n;
    idx = adr[9:2];
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_ack_o && n < 8);
    edges = wb_ack_o ? n + 1 : 0;
    check("wr_chan_we", {31'd0, chan_we_o}, {31'd0, idx < 8'hE0});
    check("wr_soft_rst", {31'd0, soft_rst_o}, {31'd0, idx == 8'hF0});
    if (idx < 8'hE0) begin
      check("wr_chan_adr", {24'd0, chan_adr_o}, {24'd0, idx});
      check("wr_chan_dat", chan_dat_o, dat);
    end
    bus_idle();
    tick();
    check("wr_strobe_width", {29'd0, wb_ack_o, chan_we_o, soft_rst_o}, 32'd0);
    tick();
    if (idx < 8'hE0) m_chan[idx] = dat;
    if (idx == 8'hF1) m_pt = dat[23:0];
    if (idx == 8'hF2) m_pa = dat[23:0];
    check("prog_tic_o", {8'd0, prog_tic_o}, {8'd0, m_pt});
    check("prog_accum_int_o", {8'd0, prog_accum_int_o}, {8'd0, m_pa});
    $display("wr adr=%h dat=%h edges=%0d", adr, dat, edges);
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [NC-1:0] clr_nd, input string name);
    logic [7:0]  idx;
    logic [31:0] exp;
    logic [31:0] got;
    int          edges;
    idx = adr[9:2];
    exp = model_read(idx);
    wb_read(adr, clr_nd, 1'b0, got, edges);
    check(name, got, exp);
    check({name, "_edges"}, 32'(edges), (idx < 8'hE0) ? 32'd3 : 32'd2);
    model_after_read(idx, clr_nd);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] dat, input string name);
    int edges;
    wb_write(adr, dat, edges);
    check({name, "_edges"}, 32'(edges), 32'd2);
  endtask

  function automatic logic [7:0] pick_idx();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2: return 8'($urandom_range(0, 15));
      3:       return 8'hE0;
      4:       return 8'hE1;
      5:       return 8'hE2;
      6:       return 8'hEF;
      7:       return 8'hF1;
      8:       return 8'hF2;
      default: return 8'($urandom_range(8'hE3, 8'hFF));
    endcase
  endfunction

  typedef struct {
    bit          we;
    bit          hold;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
    int          exp_edges;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] r32;
    int          edges;
    int          acks;

    vecs[0]  = '{1'b0, 1'b1, 32'h3BC, 32'h0,        HW,           2};
    vecs[1]  = '{1'b0, 1'b0, 32'h3C4, 32'h0,        32'h000F423F, 2};
    vecs[2]  = '{1'b0, 1'b0, 32'h3C8, 32'h0,        32'h0000C34F, 2};
    vecs[3]  = '{1'b0, 1'b0, 32'h380, 32'h0,        32'h0,        2};
    vecs[4]  = '{1'b0, 1'b0, 32'h384, 32'h0,        32'h0,        2};
    vecs[5]  = '{1'b0, 1'b0, 32'h388, 32'h0,        32'hFFFFFF00, 2};
    vecs[6]  = '{1'b0, 1'b0, 32'h3FC, 32'h0,        32'h0,        2};
    vecs[7]  = '{1'b1, 1'b0, 32'h3C4, 32'h12345678, 32'h0,        2};
    vecs[8]  = '{1'b0, 1'b0, 32'h3C4, 32'h0,        32'h00345678, 2};
    vecs[9]  = '{1'b1, 1'b0, 32'h3C8, 32'hFFABCDEF, 32'h0,        2};
    vecs[10] = '{1'b0, 1'b0, 32'h3C8, 32'h0,        32'h00ABCDEF, 2};
    vecs[11] = '{1'b1, 1'b0, 32'h3BC, 32'h0,        32'h0,        2};
    vecs[12] = '{1'b0, 1'b0, 32'h3BC, 32'h0,        HW,           2};
    vecs[13] = '{1'b1, 1'b0, 32'h3FC, 32'h1,        32'h0,        2};
    vecs[14] = '{1'b0, 1'b0, 32'h3F8, 32'h0,        32'h0,        2};

    for (int i = 0; i < 256; i++) m_chan[i] = 32'd0;
    model_reset();

    // Reset state
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_chan", {22'd0, chan_we_o, soft_rst_o, chan_adr_o}, 32'd0);
    check("rst_chan_dat", chan_dat_o, 32'd0);
    check("rst_prog_tic", {8'd0, prog_tic_o}, {8'd0, PT});
    check("rst_prog_accum", {8'd0, prog_accum_int_o}, {8'd0, PA});

    // Directed table
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].we) begin
        wb_write(vecs[i].adr, vecs[i].dat, edges);
      end else begin
        wb_read(vecs[i].adr, '0, vecs[i].hold, got, edges);
        check($sformatf("vec%0d_dat", i), got, vecs[i].exp);
        model_after_read(vecs[i].adr[9:2], '0);
      end
      check($sformatf("vec%0d_edges", i), 32'(edges), 32'(vecs[i].exp_edges));
    end

    // stb without cyc must be ignored
    wb_cyc_i = 1'b0; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h3C4; wb_dat_i = 32'h0;
    acks = 0;
    repeat (4) begin
      tick();
      if (wb_ack_o) acks++;
    end
    bus_idle();
    repeat (2) begin
      tick();
      if (wb_ack_o) acks++;
    end
    check("cyc_low_acks", 32'(acks), 32'd0);
    check("cyc_low_no_write", {8'd0, prog_tic_o}, {8'd0, m_pt});

    // Sticky status and clear-on-read
    pulse(1'b1, 1'b0, '0);
    pulse(1'b1, 1'b1, '0);
    do_read(32'h380, '0, "status_set");
    do_read(32'h380, '0, "status_cleared");
    do_read(32'h388, '0, "tic_count_2");

    // new_data, with a set landing on the clearing edge
    pulse(1'b0, 1'b0, 12'h805);
    do_read(32'h384, 12'h002, "new_data_805");
    do_read(32'h384, '0, "new_data_late_set");

    // Soft reset pulse and channel window
    do_write(32'h3C0, 32'hFFFF_FFFF, "soft_rst");
    do_write(32'h010, 32'hDEADBEEF, "chan_wr");
    do_read(32'h010, '0, "chan_rd_back");
    poke_adr = 8'h04; poke_dat = 32'hCAFEF00D; poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
    m_chan[4] = 32'hCAFEF00D;
    do_read(32'h010, '0, "chan_rd_cafe");

    // Reset while a channel read sits in its wait cycle
    do_write(32'h3C4, 32'h00ABCDEF, "prog_tic_pre_rst");
    pulse(1'b1, 1'b0, 12'h00F);
    wb_adr_i = 32'h020; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    sys_rst = 1'b1;
    acks = 0;
    tick();
    if (wb_ack_o) acks++;
    bus_idle();
    sys_rst = 1'b0;
    repeat (4) begin
      tick();
      if (wb_ack_o) acks++;
    end
    check("rst_chrd_acks", 32'(acks), 32'd0);
    check("rst_chrd_prog_tic", {8'd0, prog_tic_o}, {8'd0, PT});
    model_reset();
    do_read(32'h384, '0, "rst_new_data");
    do_read(32'h388, '0, "rst_tic_count");

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, "preload");
    for (int it = 0; it < 300; it++) begin
      logic [7:0]    idx;
      logic [NC-1:0] nd;
      r32 = $urandom & $urandom;
      nd  = r32[NC-1:0];
      case ($urandom_range(0, 2))
        0: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nd);
        1: begin
          idx = pick_idx();
          do_write({22'd0, idx, 2'b00}, $urandom, "rand_wr");
        end
        default: begin
          idx = pick_idx();
          do_read({22'd0, idx, 2'b00}, ($urandom_range(0, 3) == 0) ? nd : '0, "rand_rd");
        end
      endcase
    end

    // Drive tic_count across the 32-bit wrap
    repeat (300) pulse(1'b1, 1'b0, '0);
    do_read(32'h388, '0, "tic_count_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
